// File: rtl/line_window_pkg.sv
// Shared constants and helpers for the streaming line-window buffer.
// COL_W / ROW_W give the counter widths of the default 640x480 build;
// instances with other geometry derive their widths from their own parameters.
package line_window_pkg;

   localparam int DEF_DATA_W   = 12;
   localparam int DEF_LINE_LEN = 640;
   localparam int DEF_MAX_ROWS = 480;
   localparam int DEF_WIN      = 3;

   localparam int COL_W = $clog2(DEF_LINE_LEN);
   localparam int ROW_W = $clog2(DEF_MAX_ROWS);

   // Bit offset of window element (r,c) inside the flattened window bus;
   // r=0 is the oldest line, c=0 the oldest column.
   function automatic int win_idx(input int r, input int c, input int win, input int data_w);
      return (r * win + c) * data_w;
   endfunction

endpackage

// File: rtl/line_window_buf_ram.sv
// One circular line memory: DATA_W x DEPTH, single address, combinational
// read so the old contents are seen in the same cycle they are overwritten.
module line_ram #(
   parameter int DATA_W = 12,
   parameter int DEPTH  = 640
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [DATA_W-1:0]        wdata,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   assign rdata = mem[addr];

   // Write the accepted pixel; the read above still returns the previous line's value.
   // NOTE: the memory array has no reset -- clearing it would cost a write port per
   // entry, and row gating upstream keeps stale contents from ever reaching the output.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/line_window_buf.sv
// Streaming WIN x WIN neighbourhood generator with valid/ready handshake.
// Keeps WIN-1 previous lines in line_ram instances, a WIN x WIN shift window,
// raster counters with start-of-frame resync, and a single registered output stage.
module line_window_buf
   import line_window_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int LINE_LEN = DEF_LINE_LEN,
   parameter int MAX_ROWS = DEF_MAX_ROWS,
   parameter int WIN      = DEF_WIN
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          in_sof,
   input  logic [DATA_W-1:0]             in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIN*WIN*DATA_W-1:0]     out_win,
   output logic [$clog2(LINE_LEN)-1:0]   out_col,
   output logic [$clog2(MAX_ROWS)-1:0]   out_row
);

   localparam int CW = $clog2(LINE_LEN);
   localparam int RW = $clog2(MAX_ROWS);

   localparam logic [CW-1:0] COL_LAST = CW'(LINE_LEN - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(MAX_ROWS - 1);
   localparam logic [CW-1:0] COL_MIN  = CW'(WIN - 1);
   localparam logic [RW-1:0] ROW_MIN  = RW'(WIN - 1);

   logic                     accept;
   logic                     win_ok;
   logic [CW-1:0]            col_q;
   logic [RW-1:0]            row_q;
   logic [CW-1:0]            pix_col;
   logic [RW-1:0]            pix_row;
   logic [DATA_W-1:0]        line_rd [WIN-1];
   logic [DATA_W-1:0]        win_q   [WIN][WIN];
   logic [DATA_W-1:0]        win_d   [WIN][WIN];
   logic [WIN*WIN*DATA_W-1:0] win_flat;

   // Single output stage: space exists when empty or being drained this cycle.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // Coordinates of the pixel on the input; a start-of-frame pins it to the origin.
   assign pix_col = in_sof ? '0 : col_q;
   assign pix_row = in_sof ? '0 : row_q;
   assign win_ok  = (pix_row >= ROW_MIN) && (pix_col >= COL_MIN);

   // Line memory chain: memory 0 holds row-1, memory k holds row-1-k.
   for (genvar k = 0; k < WIN - 1; k++) begin : g_line
      logic [DATA_W-1:0] wdata;
      if (k == 0) begin : g_head
         assign wdata = in_data;
      end else begin : g_tail
         assign wdata = line_rd[k-1];
      end
      line_ram #(
         .DATA_W (DATA_W),
         .DEPTH  (LINE_LEN)
      ) u_ram (
         .clk   (clk),
         .we    (accept),
         .addr  (pix_col),
         .wdata (wdata),
         .rdata (line_rd[k])
      );
   end

   // Next window: every column moves one step older, the fresh column enters on the right.
   // NOTE: every element of win_d is written on every pass, so no latch is inferred.
   always_comb begin
      for (int r = 0; r < WIN; r++) begin
         for (int c = 0; c < WIN - 1; c++) begin
            win_d[r][c] = win_q[r][c+1];
         end
      end
      for (int r = 0; r < WIN - 1; r++) begin
         win_d[r][WIN-1] = line_rd[WIN-2-r];
      end
      win_d[WIN-1][WIN-1] = in_data;
   end

   // Flatten the next window into the output bus layout.
   always_comb begin
      win_flat = '0;
      for (int r = 0; r < WIN; r++) begin
         for (int c = 0; c < WIN; c++) begin
            win_flat[win_idx(r, c, WIN, DATA_W) +: DATA_W] = win_d[r][c];
         end
      end
   end

   // Raster counters and window register advance once per accepted pixel.
   // NOTE: state registers use non-blocking assignment so every flop samples
   // pre-edge values regardless of the order the statements appear in.
   always_ff @(posedge clk) begin
      if (!rst) begin
         col_q <= '0;
         row_q <= '0;
         win_q <= '{default: '0};
      end else if (accept) begin
         if (pix_col == COL_LAST) begin
            col_q <= '0;
            row_q <= (pix_row == ROW_LAST) ? '0 : pix_row + RW'(1);
         end else begin
            col_q <= pix_col + CW'(1);
            row_q <= pix_row;
         end
         win_q <= win_d;
      end
   end

   // Output register: loads a completed window, holds everything while stalled.
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_win   <= '0;
         out_col   <= '0;
         out_row   <= '0;
      end else if (in_ready) begin
         out_valid <= accept && win_ok;
         if (accept && win_ok) begin
            out_win <= win_flat;
            out_col <= pix_col;
            out_row <= pix_row;
         end
      end
   end

endmodule

// File: tb/tb_line_window_buf.sv
// Directed bench for line_window_buf: a 3x3 and a 5x5 instance on an 8x8 frame,
// pixel value = row*16 + col.
module tb_line_window_buf;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_sof;
   logic [11:0]  in_data;
   logic         out_ready;

   logic         in_ready3, out_valid3;
   logic [107:0] out_win3;
   logic [2:0]   out_col3, out_row3;

   logic         in_ready5, out_valid5;
   logic [299:0] out_win5;
   logic [2:0]   out_col5, out_row5;

   int total = 0;
   int bad   = 0;

   logic [107:0] q3_win [$];
   int           q3_col [$];
   int           q3_row [$];
   logic [299:0] q5_win [$];
   int           q5_col [$];
   int           q5_row [$];

   always #5 clk = ~clk;

   line_window_buf #(.DATA_W(12), .LINE_LEN(8), .MAX_ROWS(8), .WIN(3)) dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3), .in_sof(in_sof),
      .in_data(in_data), .out_valid(out_valid3), .out_ready(out_ready), .out_win(out_win3),
      .out_col(out_col3), .out_row(out_row3));

   line_window_buf #(.DATA_W(12), .LINE_LEN(8), .MAX_ROWS(8), .WIN(5)) dut5 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready5), .in_sof(in_sof),
      .in_data(in_data), .out_valid(out_valid5), .out_ready(out_ready), .out_win(out_win5),
      .out_col(out_col5), .out_row(out_row5));

   // Record every window handed over (valid && ready at the coming edge).
   always @(negedge clk) begin
      if (rst === 1'b1 && out_valid3 && out_ready) begin
         q3_win.push_back(out_win3); q3_col.push_back(int'(out_col3)); q3_row.push_back(int'(out_row3));
      end
      if (rst === 1'b1 && out_valid5 && out_ready) begin
         q5_win.push_back(out_win5); q5_col.push_back(int'(out_col5)); q5_row.push_back(int'(out_row5));
      end
   end

   function automatic logic [107:0] exp_win3(input int r, input int c);
      logic [107:0] v;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            v[(i*3+j)*12 +: 12] = 12'((r - 2 + i) * 16 + (c - 2 + j));
      return v;
   endfunction

   function automatic logic [299:0] exp_win5(input int r, input int c);
      logic [299:0] v;
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++)
            v[(i*5+j)*12 +: 12] = 12'((r - 4 + i) * 16 + (c - 4 + j));
      return v;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_queues();
      q3_win.delete(); q3_col.delete(); q3_row.delete();
      q5_win.delete(); q5_col.delete(); q5_row.delete();
   endtask

   task automatic do_reset();
      rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = 1'b1;
      cyc(); cyc();
      rst = 1'b1;
      clear_queues();
   endtask

   // Present one pixel until accepted, then check out_valid for the coordinates (r,c)
   // the pixel is supposed to take.
   task automatic push_pixel(input int r, input int c, input logic [11:0] d, input logic sof,
                             input bit use5, input bit bubbles);
      bit acc;
      int n;
      int w;
      logic ov;
      if (bubbles && $urandom_range(0, 1) == 1) begin
         in_valid = 1'b0;
         cyc();
      end
      in_valid = 1'b1; in_data = d; in_sof = sof;
      acc = 1'b0; n = 0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = use5 ? in_ready5 : in_ready3;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0; in_sof = 1'b0;
      if (!acc) begin
         total++; bad++;
         $display("FAIL accept_timeout pixel (%0d,%0d): not accepted within 50 cycles", r, c);
      end
      w  = use5 ? 5 : 3;
      ov = use5 ? out_valid5 : out_valid3;
      total++;
      if (ov !== ((r >= w - 1) && (c >= w - 1))) begin
         bad++;
         $display("FAIL out_valid win%0d after (%0d,%0d): got %b want %b", w, r, c, ov,
                  ((r >= w - 1) && (c >= w - 1)));
      end
   endtask

   task automatic stream_lines(input int first_row, input int nrows, input bit bubbles, input bit use5);
      for (int r = first_row; r < first_row + nrows; r++)
         for (int c = 0; c < 8; c++)
            push_pixel(r % 8, c, 12'(((r % 8) * 16) + c), 1'b0, use5, bubbles);
   endtask

   task automatic verify_three_lines(input string name);
      total++;
      if (q3_win.size() != 6) begin
         bad++;
         $display("FAIL %s window count: got %0d want 6", name, q3_win.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            total++;
            if (q3_win[i] !== exp_win3(2, i + 2)) begin
               bad++;
               $display("FAIL %s window %0d: got %h want %h", name, i, q3_win[i], exp_win3(2, i + 2));
            end
            total++;
            if (q3_col[i] != i + 2 || q3_row[i] != 2) begin
               bad++;
               $display("FAIL %s coord %0d: got (%0d,%0d) want (2,%0d)", name, i, q3_row[i], q3_col[i], i + 2);
            end
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (out_valid3 !== 1'b0 || out_win3 !== '0 || out_col3 !== 3'd0 || out_row3 !== 3'd0) begin
         bad++;
         $display("FAIL reset_outputs3: got v=%b win=%h col=%0d row=%0d want all zero",
                  out_valid3, out_win3, out_col3, out_row3);
      end
      total++;
      if (out_valid5 !== 1'b0 || out_win5 !== '0) begin
         bad++;
         $display("FAIL reset_outputs5: got v=%b win=%h want zero", out_valid5, out_win5);
      end
      total++;
      if (in_ready3 !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready3);
      end
   endtask

   task automatic test_stream();
      logic [107:0] first;
      do_reset();
      stream_lines(0, 3, 1'b0, 1'b0);
      cyc();
      first = {12'h022, 12'h021, 12'h020, 12'h012, 12'h011, 12'h010, 12'h002, 12'h001, 12'h000};
      total++;
      if (q3_win.size() == 0 || q3_win[0] !== first) begin
         bad++;
         $display("FAIL stream_first_window: got %h want %h",
                  (q3_win.size() == 0) ? 108'h0 : q3_win[0], first);
      end
      verify_three_lines("stream");
   endtask

   task automatic test_stall();
      do_reset();
      stream_lines(0, 2, 1'b0, 1'b0);
      for (int c = 0; c < 5; c++) push_pixel(2, c, 12'(32 + c), 1'b0, 1'b0, 1'b0);
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 12'h025; in_sof = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total++;
         if (out_valid3 !== 1'b1 || out_win3 !== exp_win3(2, 4) || out_col3 !== 3'd4) begin
            bad++;
            $display("FAIL stall_hold cycle %0d: got v=%b col=%0d win=%h want v=1 col=4 win=%h",
                     k, out_valid3, out_col3, out_win3, exp_win3(2, 4));
         end
         total++;
         if (out_win3[11:0] !== 12'h002 || in_ready3 !== 1'b0) begin
            bad++;
            $display("FAIL stall_ready cycle %0d: got tl=%h in_ready=%b want tl=002 in_ready=0",
                     k, out_win3[11:0], in_ready3);
         end
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      cyc();
      in_valid = 1'b0;
      total++;
      if (out_valid3 !== 1'b1 || out_col3 !== 3'd5 || out_row3 !== 3'd2 || out_win3 !== exp_win3(2, 5)) begin
         bad++;
         $display("FAIL stall_release: got v=%b (%0d,%0d) win=%h want v=1 (2,5) win=%h",
                  out_valid3, out_row3, out_col3, out_win3, exp_win3(2, 5));
      end
   endtask

   task automatic test_bubbles();
      do_reset();
      stream_lines(0, 3, 1'b1, 1'b0);
      cyc();
      verify_three_lines("bubbles");
   endtask

   task automatic test_sof_resync();
      logic [107:0] want;
      do_reset();
      stream_lines(0, 3, 1'b0, 1'b0);
      for (int c = 0; c < 5; c++) push_pixel(3, c, 12'(48 + c), 1'b0, 1'b0, 1'b0);
      push_pixel(0, 0, 12'h0AA, 1'b1, 1'b0, 1'b0);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 8; c++)
            if (!(r == 0 && c == 0) && (r < 2 || c <= 2))
               push_pixel(r, c, 12'(r * 16 + c), 1'b0, 1'b0, 1'b0);
      want = exp_win3(2, 2);
      want[11:0] = 12'h0AA;
      total++;
      if (out_win3 !== want || out_row3 !== 3'd2 || out_col3 !== 3'd2) begin
         bad++;
         $display("FAIL sof_window: got (%0d,%0d) %h want (2,2) %h", out_row3, out_col3, out_win3, want);
      end
      total++;
      if (out_win3[11:0] !== 12'h0AA || out_win3[96 +: 12] !== 12'h022) begin
         bad++;
         $display("FAIL sof_corners: got tl=%h br=%h want tl=0aa br=022", out_win3[11:0], out_win3[96 +: 12]);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      stream_lines(0, 2, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) push_pixel(2, c, 12'(32 + c), 1'b0, 1'b0, 1'b0);
      rst = 1'b0; in_valid = 1'b1; in_data = 12'h023;
      cyc();
      in_valid = 1'b0;
      total++;
      if (out_valid3 !== 1'b0 || out_win3 !== '0 || out_col3 !== 3'd0 || out_row3 !== 3'd0) begin
         bad++;
         $display("FAIL reset_mid: got v=%b win=%h (%0d,%0d) want all zero", out_valid3, out_win3, out_row3, out_col3);
      end
      rst = 1'b1;
      clear_queues();
      stream_lines(0, 3, 1'b0, 1'b0);
      cyc();
      verify_three_lines("reset_mid");
   endtask

   task automatic test_win5();
      do_reset();
      stream_lines(0, 8, 1'b0, 1'b1);
      stream_lines(0, 4, 1'b0, 1'b1);
      for (int c = 0; c < 5; c++) push_pixel(4, c, 12'(64 + c), 1'b0, 1'b1, 1'b0);
      cyc();
      total++;
      if (q5_win.size() != 17) begin
         bad++;
         $display("FAIL win5_count: got %0d want 17", q5_win.size());
      end else begin
         total++;
         if (q5_win[0][11:0] !== 12'h000 || q5_win[0][288 +: 12] !== 12'h044) begin
            bad++;
            $display("FAIL win5_first_corners: got tl=%h br=%h want tl=000 br=044",
                     q5_win[0][11:0], q5_win[0][288 +: 12]);
         end
         for (int i = 0; i < 17; i++) begin
            int er;
            int ec;
            er = (i < 16) ? 4 + i / 4 : 4;
            ec = (i < 16) ? 4 + i % 4 : 4;
            total++;
            if (q5_win[i] !== exp_win5(er, ec) || q5_row[i] != er || q5_col[i] != ec) begin
               bad++;
               $display("FAIL win5_window %0d: got (%0d,%0d) %h want (%0d,%0d) %h",
                        i, q5_row[i], q5_col[i], q5_win[i], er, ec, exp_win5(er, ec));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_bubbles();
      test_sof_resync();
      test_reset_mid();
      test_win5();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
